// File: rtl/regfile_pkg.sv
// Shared register-file constants and a width helper for index ports.
package regfile_pkg;

  localparam int RF_AW    = 4;
  localparam int RF_DW    = 64;
  localparam int RF_DEPTH = 16;

  // Number of bits needed to encode values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first valid requester at or after i_ptr,
// wrapping modulo NREQ. Produces one-hot grant, encoded index and any flag.
module rr_priority_pick
  import regfile_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  // Scan ptr, ptr+1, ... and keep only the first valid hit.
  always_comb begin
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_pos;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= NREQ_W) begin
        w_sum = w_sum - NREQ_W;
      end
      w_pos = w_sum[PW-1:0];
      if (!o_any && i_valid[w_pos]) begin
        o_any          = 1'b1;
        o_idx          = w_pos;
        o_grant[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ
// writeback requesters. Grants are combinational; the granted write is
// registered and presented on wena/waddr/wdata one cycle later.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic                     stall,
  output logic                     wena,
  output logic [AW-1:0]            waddr,
  output logic [DW-1:0]            wdata,
  output logic [clog2(NREQ)-1:0]   last_grant,
  output logic                     busy
);

  localparam int PW = clog2(NREQ);

  logic [PW-1:0]   r_ptr;
  logic            r_wena;
  logic [AW-1:0]   r_waddr;
  logic [DW-1:0]   r_wdata;
  logic [PW-1:0]   r_last_grant;

  logic [NREQ-1:0] w_valid_eff;
  logic [NREQ-1:0] w_grant_oh;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;
  logic [PW-1:0]   w_ptr_next;

  // Stall and reset mask every request, so no ready can rise while either holds.
  always_comb begin
    w_valid_eff = req_valid;
    if (stall || !RST) begin
      w_valid_eff = '0;
    end
  end

  rr_priority_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_valid (w_valid_eff),
    .i_ptr   (r_ptr),
    .o_grant (w_grant_oh),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Select the granted requester's address/data from the flattened buses.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_idx == PW'(i)) begin
        w_sel_addr = req_addr[i*AW +: AW];
        w_sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Pointer moves just past the winner, wrapping after the last requester.
  always_comb begin
    w_ptr_next = w_idx + 1'b1;
    if (w_idx == PW'(NREQ-1)) begin
      w_ptr_next = '0;
    end
  end

  // Output register stage and RR pointer; non-grant cycles hold addr/data/index.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ptr        <= '0;
      r_wena       <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_last_grant <= '0;
    end else begin
      r_wena <= w_any;
      if (w_any) begin
        r_waddr      <= w_sel_addr;
        r_wdata      <= w_sel_data;
        r_last_grant <= w_idx;
        r_ptr        <= w_ptr_next;
      end
    end
  end

  assign req_ready  = w_grant_oh;
  assign wena       = r_wena;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign last_grant = r_last_grant;
  assign busy       = |req_valid;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 16x64 register file between NREQ writeback requesters, e.g. the per-thread ALU and load writeback paths of the 2-core/4-thread core.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the granted write and drives the register file wena/waddr/wdata one cycle later.
- Provides a stall input so pipeline control can freeze all writeback.

Parameters:
- NREQ, 4, number of writeback requesters (2..8).
- DW, 64, write data width.
- AW, 4, register address width (16 registers).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester write request.
- req_ready  output  NREQ  per-requester grant/accept (combinational).
- req_addr  input  NREQ*AW  flattened target addresses; requester i uses bits [i*AW +: AW].
- req_data  input  NREQ*DW  flattened write data; requester i uses bits [i*DW +: DW].
- stall  input  1  when high, no grants are issued.
- wena  output  1  register file write enable (registered).
- waddr  output  AW  register file write address (registered).
- wdata  output  DW  register file write data (registered).
- last_grant  output  log2(NREQ)  index of the requester whose write is on wena (registered).
- busy  output  1  high while any req_valid is high.

Behaviour:
- Reset (RST=0, asynchronous):
  - wena=0, waddr=0, wdata=0, last_grant=0.
  - RR pointer ptr=0.
  - A grant issued in the cycle of reset assertion is dropped; the register file is cleared by the same reset.
- Handshake:
  - Requester i holds valid/addr/data stable until it sees req_valid[i] & req_ready[i] at a rising edge.
  - At most one req_ready bit is high in any cycle.
  - req_ready[i] depends on req_valid and stall only, never on addr/data.
- Arbitration, combinational in cycle t:
  - If stall=1 or req_valid=0, then req_ready=0.
  - Otherwise grant the first valid requester scanning ptr, ptr+1, ..., wrapping modulo NREQ.
- Update at the edge ending cycle t:
  - If a grant g occurred: wena<=1, waddr<=addr[g], wdata<=data[g], last_grant<=g, ptr<=(g+1) mod NREQ.
  - If no grant occurred: wena<=0, ptr unchanged; waddr, wdata and last_grant hold their values.
- Latency: the accepted request is presented to the register file in cycle t+1 and committed at the edge ending t+1, so it is readable from cycle t+2.
- Throughput: one write per cycle sustained. A continuously valid single requester is granted every cycle.
- Fairness: with all NREQ requesters valid, each is granted exactly once in every NREQ consecutive cycles.
- Same address from multiple requesters: no merging. Writes land in grant order, so the last-granted value wins.
- Stall:
  - Stall takes effect in the same cycle.
  - The write already registered still completes (wena stays high for that one cycle).
  - ptr is frozen during stall.
- Wrap: a grant to requester NREQ-1 sets ptr to 0.
- No internal queue. Backpressure is applied purely through req_ready.

Decomposition:
- Shared package regfile_pkg holds RF_AW=4, RF_DW=64, RF_DEPTH=16 and a function clog2 for the last_grant width.
- One natural sub-module, rr_priority_pick, which is combinational:
  - Inputs: valid vector and ptr.
  - Outputs: one-hot grant, encoded index and any_grant.
- regfile_wb_arbiter holds ptr, the output register stage and the stall gating.

Test Plan:
- Reset with req_valid=4'b1111 held: wena=0 and req_ready=0 during reset. After release, the first grant is req 0 (ptr=0). The next cycle shows wena=1, waddr=addr0, last_grant=0.
- All four requesters valid continuously with addr=i and data=64'hA0+i: grants cycle 0,1,2,3,0,... and wena stays high every cycle. Register file contents match 64'hA0..A3.
- Only req 2 valid, addr=4'd5, data=64'hDEAD_BEEF, held 3 cycles: req_ready[2]=1 each cycle and wena=1 for 3 consecutive cycles with waddr=5. After release, ptr=3.
- Req 1 and req 3 both target addr 4'd7 (data 64'h11, 64'h33), ptr=0: req 1 is granted first, then req 3. The register file ends with r7=64'h33.
- stall=1 asserted one cycle after a grant to req 0, with all requesters valid: wena=1 for one more cycle, then 0. req_ready=0 and ptr=1 held throughout stall. The first grant after stall falls is req 1.
- RST pulsed low while requesters are valid mid-stream: wena drops asynchronously to 0 and ptr=0. After release, arbitration resumes from req 0.
